// File: rtl/adder_pkg.sv
// Shared types for the serial adder family: the controller state encoding
// and the default operand width.
package adder_pkg;

  localparam int ADD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
// Ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(parameter int WIDTH = adder_pkg::ADD_WIDTH);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             Ovf;

  modport master (output start, A, B, Cin, input busy, done, Sum, Cout, Ovf);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout, Ovf);
`else
  modport master (output start, A, B, Cin, input busy, done, Sum, Cout);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout);
`endif
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial adder datapath.
module full_adder (
  input  logic X,
  input  logic Y,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = X ^ Y ^ Cin;
  assign Cout = (X & Y) | (Cin & (X ^ Y));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full adder, one bit per cycle, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  add_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_r;
  logic             carry, cout_r;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             accept, last;

  full_adder u_fa (
    .X    (a_sr[0]),
    .Y    (b_sr[0]),
    .Cin  (carry),
    .Sum  (fa_s),
    .Cout (fa_c)
  );

  // start is only honoured outside RUN; DONE accepts it for back-to-back adds
  assign accept = bus.start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= bus.A;
      b_sr  <= bus.B;
      carry <= bus.Cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_r  <= {fa_s, sum_r[WIDTH-1:1]};
      carry  <= fa_c;
      cout_r <= fa_c;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_r;

  // On the MSB step, carry holds the carry into the MSB and fa_c the carry out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf_r <= 1'b0;
    else if (accept) ovf_r <= 1'b0;
    else if (last)   ovf_r <= carry ^ fa_c;
  end

  assign bus.Ovf = ovf_r;
`endif

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.Sum  = sum_r;
  assign bus.Cout = cout_r;

endmodule
